elevator_scheduler: RTL and testbench
=====================================

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter TRAVEL_CYC, default 8, clock cycles the car spends moving between adjacent floors (legal range 2..255).
REQ-002 Parameter DOOR_CYC, default 4, clock cycles the door stays open per stop (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 call_req  input  4  one-cycle floor call pulses, bit f = floor f (0 = ground, 3 = top).
REQ-006 floor  output  2  current car floor.
REQ-007 motor_up / motor_down  output  1 each  drive commands, never both 1.
REQ-008 door_open  output  1  door command.
REQ-009 pending  output  4  latched outstanding calls.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 States: IDLE, MOVE_UP, MOVE_DOWN, DOOR; encoded 2-bit; plus a dir_up register holding the last travel direction.
REQ-012 pending[f] sets on the cycle after call_req[f]=1 and holds until served; set and clear of the same bit in one cycle resolve to clear (the call is served).
REQ-013 IDLE, pending[floor]=1: next state DOOR, pending[floor] cleared.
REQ-014 IDLE, only other floors pending: go to MOVE_UP if dir_up=1 and any call above floor, or if no call below; otherwise MOVE_DOWN; the decision takes 1 cycle; dir_up updates to match.
REQ-015 IDLE, pending=0: stay IDLE, all outputs except floor and pending low.
REQ-016 MOVE_UP/MOVE_DOWN: motor_up or motor_down high for exactly TRAVEL_CYC cycles per floor, then floor increments/decrements by 1.
REQ-017 On arrival: if pending[new floor]=1, go to DOOR and clear that bit; else if calls remain further in the same direction, continue moving (timer reloads, no idle cycle); else go to IDLE.
REQ-018 floor never increments past 3 nor decrements below 0; MOVE_UP is never entered at floor 3, MOVE_DOWN never at floor 0.
REQ-019 DOOR: door_open high for exactly DOOR_CYC cycles, then IDLE; a call for the current floor arriving during DOOR reloads the timer to DOOR_CYC and is cleared immediately.
REQ-020 Calls for other floors arriving during motion or DOOR only latch into pending; they are served per REQ-014/REQ-017 (SCAN order).
REQ-021 motor_up, motor_down and door_open are registered and mutually exclusive in every cycle.

Reset
REQ-022 While rst=1: state IDLE, floor=0, dir_up=1, pending=0, timers=0, motor_up=motor_down=door_open=busy=0.
REQ-023 Reset asserted mid-travel or mid-door takes effect immediately (asynchronous); the first call_req is sampled on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro ESTOP_EN: when defined, adds input estop (1 bit); while estop=1, motor_up=motor_down=0, door_open=0, travel and door timers freeze, state and pending hold, calls still latch; on estop=0 operation resumes from the frozen count.
REQ-025 Without ESTOP_EN: no estop port; behaviour exactly as REQ-011..REQ-023.

Verification
REQ-026 Reset, pulse call_req=4'b1000 -> MOVE_UP 1 cycle later, motor_up high 3x8=24 cycles, floor 0->1->2->3, door_open 4 cycles, pending returns to 0, IDLE.
REQ-027 At floor 0 idle, pulse call_req=4'b0001 -> DOOR next cycle, door_open 4 cycles, no motor activity.
REQ-028 At floor 0, calls 4'b1000 then 4'b0100 while moving up from 0 -> stops at floor 2 (door 4 cycles), then continues to 3.
REQ-029 At floor 1 with dir_up=1, calls 4'b0001 and 4'b1000 simultaneously -> serves 3 first, then 0.
REQ-030 During DOOR at floor 2, call_req=4'b0100 on the 3rd door cycle -> door_open total 3+4=7 cycles, pending[2] stays 0.
REQ-031 rst asserted on the 5th travel cycle 0->1 -> floor=0, motors low, pending=0 in the same cycle; with ESTOP_EN, estop high for 10 cycles mid-travel -> motor low 10 cycles, total travel 8 active cycles.

Source files
------------

// File: rtl/elevator_scheduler_if.sv
// Elevator scheduler bus: floor calls in, car status and drive commands out.
// The estop signal exists only when ESTOP_EN is defined.
interface elevator_scheduler_if;
    logic [3:0] call_req;
    logic [1:0] floor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [3:0] pending;
    logic       busy;
`ifdef ESTOP_EN
    logic       estop;

    modport master (
        output call_req, estop,
        input  floor, motor_up, motor_down, door_open, pending, busy
    );
    modport slave (
        input  call_req, estop,
        output floor, motor_up, motor_down, door_open, pending, busy
    );
`else
    modport master (
        output call_req,
        input  floor, motor_up, motor_down, door_open, pending, busy
    );
    modport slave (
        input  call_req,
        output floor, motor_up, motor_down, door_open, pending, busy
    );
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// Four-floor SCAN elevator controller with latched calls, travel and door timers.
// Optional macro ESTOP_EN adds an emergency-stop input that freezes motion and timers.
module elevator_scheduler #(
    parameter int unsigned TRAVEL_CYC = 8,
    parameter int unsigned DOOR_CYC   = 4
) (
    input logic                 clk,
    input logic                 rst,
    elevator_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

    localparam logic [7:0] TravelLoad = 8'(TRAVEL_CYC);
    localparam logic [7:0] DoorLoad   = 8'(DOOR_CYC);

    state_e     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic       dir_up_q, dir_up_d;
    logic [3:0] pending_q, pending_d;
    logic [7:0] timer_q, timer_d;
    logic       motor_up_q, motor_down_q, door_open_q, busy_q;

    logic       freeze;
    logic [3:0] clr;
    logic [3:0] above, below, above_up, below_dn;
    logic [1:0] floor_up, floor_dn;

`ifdef ESTOP_EN
    assign freeze = bus.estop;
`else
    assign freeze = 1'b0;
`endif

    assign floor_up = floor_q + 2'd1;
    assign floor_dn = floor_q - 2'd1;
    assign above    = pending_q & (4'b1110 << floor_q);
    assign below    = pending_q & ~(4'b1111 << floor_q);
    assign above_up = pending_q & (4'b1110 << floor_up);
    assign below_dn = pending_q & ~(4'b1111 << floor_dn);

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        clr      = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (freeze) begin
                    state_d = state_q;
                end else if (pending_q[floor_q]) begin
                    state_d        = StDoor;
                    timer_d        = DoorLoad;
                    clr[floor_q]   = 1'b1;
                end else if (|pending_q) begin
                    timer_d = TravelLoad;
                    // Keep heading the same way while calls lie ahead, else reverse.
                    if ((dir_up_q && |above) || !(|below)) begin
                        state_d  = StMoveUp;
                        dir_up_d = 1'b1;
                    end else begin
                        state_d  = StMoveDown;
                        dir_up_d = 1'b0;
                    end
                end
            end
            StMoveUp: begin
                if (!freeze) begin
                    if (timer_q > 8'd1) begin
                        timer_d = timer_q - 8'd1;
                    end else begin
                        floor_d = floor_up;
                        if (pending_q[floor_up]) begin
                            state_d       = StDoor;
                            timer_d       = DoorLoad;
                            clr[floor_up] = 1'b1;
                        end else if (|above_up) begin
                            timer_d = TravelLoad;
                        end else begin
                            state_d = StIdle;
                            timer_d = 8'd0;
                        end
                    end
                end
            end
            StMoveDown: begin
                if (!freeze) begin
                    if (timer_q > 8'd1) begin
                        timer_d = timer_q - 8'd1;
                    end else begin
                        floor_d = floor_dn;
                        if (pending_q[floor_dn]) begin
                            state_d       = StDoor;
                            timer_d       = DoorLoad;
                            clr[floor_dn] = 1'b1;
                        end else if (|below_dn) begin
                            timer_d = TravelLoad;
                        end else begin
                            state_d = StIdle;
                            timer_d = 8'd0;
                        end
                    end
                end
            end
            StDoor: begin
                // A call at the open floor is absorbed and holds the door open longer.
                if (bus.call_req[floor_q]) begin
                    timer_d      = DoorLoad;
                    clr[floor_q] = 1'b1;
                end else if (!freeze) begin
                    if (timer_q > 8'd1) begin
                        timer_d = timer_q - 8'd1;
                    end else begin
                        state_d = StIdle;
                        timer_d = 8'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        pending_d = (pending_q | bus.call_req) & ~clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            floor_q      <= 2'd0;
            dir_up_q     <= 1'b1;
            pending_q    <= 4'b0000;
            timer_q      <= 8'd0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_up_q     <= dir_up_d;
            pending_q    <= pending_d;
            timer_q      <= timer_d;
            motor_up_q   <= (state_d == StMoveUp);
            motor_down_q <= (state_d == StMoveDown);
            door_open_q  <= (state_d == StDoor);
            busy_q       <= (state_d != StIdle);
        end
    end

    assign bus.floor      = floor_q;
    assign bus.pending    = pending_q;
    assign bus.busy       = busy_q;
    assign bus.motor_up   = motor_up_q & ~freeze;
    assign bus.motor_down = motor_down_q & ~freeze;
    assign bus.door_open  = door_open_q & ~freeze;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: table of single-pulse trips, corner
// sequences and a randomized run against a cycle-level behavioural model.
module tb_elevator_scheduler;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;
    localparam int MIdle = 0, MTravel = 1, MDoor = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    elevator_scheduler_if bus ();

    elevator_scheduler #(
        .TRAVEL_CYC(TRAVEL),
        .DOOR_CYC  (DOOR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: car position, activity, cycles spent in that activity, calls.
    int       m_floor;
    int       m_mode;
    int       m_cnt;
    bit       m_up;
    bit [3:0] m_pend;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, got, got, want,
                     want, $time);
        end
    endtask

    function automatic bit calls_beyond(input int f, input bit up, input bit [3:0] p);
        for (int g = 0; g < 4; g++) begin
            if (p[g] && (up ? (g > f) : (g < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0;
        m_mode  = MIdle;
        m_cnt   = 0;
        m_up    = 1'b1;
        m_pend  = 4'b0000;
    endtask

    task automatic model_step(input bit [3:0] c);
        bit [3:0] served = 4'b0000;
        case (m_mode)
            MIdle: begin
                if (m_pend[m_floor]) begin
                    m_mode = MDoor;
                    m_cnt  = 0;
                    served[m_floor] = 1'b1;
                end else if (m_pend != 4'b0000) begin
                    m_up   = (m_up && calls_beyond(m_floor, 1'b1, m_pend)) ||
                             !calls_beyond(m_floor, 1'b0, m_pend);
                    m_mode = MTravel;
                    m_cnt  = 0;
                end
            end
            MTravel: begin
                m_cnt++;
                if (m_cnt == TRAVEL) begin
                    m_floor = m_floor + (m_up ? 1 : -1);
                    m_cnt   = 0;
                    if (m_pend[m_floor]) begin
                        m_mode = MDoor;
                        served[m_floor] = 1'b1;
                    end else if (!calls_beyond(m_floor, m_up, m_pend)) begin
                        m_mode = MIdle;
                    end
                end
            end
            default: begin
                if (c[m_floor]) begin
                    m_cnt = 0;
                    served[m_floor] = 1'b1;
                end else begin
                    m_cnt++;
                    if (m_cnt == DOOR) m_mode = MIdle;
                end
            end
        endcase
        m_pend = (m_pend | c) & ~served;
    endtask

    function automatic int dut_word();
        return int'({bus.floor, bus.motor_up, bus.motor_down, bus.door_open, bus.busy,
                     bus.pending});
    endfunction

    function automatic int model_word();
        logic [1:0] f = 2'(m_floor);
        return int'({f, (m_mode == MTravel) && m_up, (m_mode == MTravel) && !m_up,
                     m_mode == MDoor, m_mode != MIdle, m_pend});
    endfunction

    // Called at a falling edge: drive calls for one cycle, then compare at the next fall.
    task automatic tick(input logic [3:0] c);
        bus.call_req = c;
        @(posedge clk);
        model_step(c);
        @(negedge clk);
        bus.call_req = 4'b0000;
        check("cycle", dut_word(), model_word());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.call_req = 4'b0000;
        @(negedge clk);
        check("reset_state", dut_word(), 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_to_idle(input int limit, output int up_c, output int dn_c,
                               output int door_c, output int fdoor, output int fmot);
        bit seen = 1'b0;
        bit done = 1'b0;
        up_c = 0; dn_c = 0; door_c = 0; fdoor = -1; fmot = 0;
        for (int i = 0; i < limit && !done; i++) begin
            tick(4'b0000);
            if (bus.motor_up)   up_c++;
            if (bus.motor_down) dn_c++;
            if (bus.door_open)  door_c++;
            if (bus.door_open && fdoor < 0) fdoor = int'(bus.floor);
            if (fmot == 0 && bus.motor_up)   fmot = 1;
            if (fmot == 0 && bus.motor_down) fmot = 2;
            if (bus.busy) seen = 1'b1;
            if (seen && !bus.busy && bus.pending == 4'b0000) done = 1'b1;
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0] calls;
        int         up_cyc;
        int         dn_cyc;
        int         door_cyc;
        int         final_floor;
    } trip_t;

    initial begin
        trip_t trips[6];
        int up_c, dn_c, door_c, fdoor, fmot;

        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        trip_t trips[6];
        int up_c, dn_c, door_c, fdoor, fmot;
        int  seen_motor;
        bit  injected, pend2, seen, done;
        logic [3:0] c;

        trips[0] = '{4'b1000, 3 * TRAVEL, 0, DOOR, 3};
        trips[1] = '{4'b0001, 0, 0, DOOR, 0};
        trips[2] = '{4'b0100, 2 * TRAVEL, 0, DOOR, 2};
        trips[3] = '{4'b1010, 3 * TRAVEL, 0, 2 * DOOR, 3};
        trips[4] = '{4'b1111, 3 * TRAVEL, 0, 4 * DOOR, 3};
        trips[5] = '{4'b0011, TRAVEL, 0, 2 * DOOR, 1};

        bus.call_req = 4'b0000;
`ifdef ESTOP_EN
        bus.estop = 1'b0;
`endif
        model_reset();
        @(negedge clk);

        foreach (trips[k]) begin
            do_reset();
            tick(trips[k].calls);
            check("pending_latch", int'(bus.pending), int'(trips[k].calls));
            run_to_idle(500, up_c, dn_c, door_c, fdoor, fmot);
            check("trip_up_cycles", up_c, trips[k].up_cyc);
            check("trip_down_cycles", dn_c, trips[k].dn_cyc);
            check("trip_door_cycles", door_c, trips[k].door_cyc);
            check("trip_final_floor", int'(bus.floor), trips[k].final_floor);
        end

        // Call for floor 2 arrives while the car is already heading to 3.
        do_reset();
        tick(4'b1000);
        repeat (3) tick(4'b0000);
        tick(4'b0100);
        run_to_idle(500, up_c, dn_c, door_c, fdoor, fmot);
        check("scan_first_stop", fdoor, 2);
        check("scan_door_cycles", door_c, 2 * DOOR);
        check("scan_up_cycles", up_c, 3 * TRAVEL - 4);
        check("scan_final_floor", int'(bus.floor), 3);

        // At floor 1 heading up, calls at 0 and 3 together: 3 is served first.
        do_reset();
        tick(4'b0010);
        run_to_idle(500, up_c, dn_c, door_c, fdoor, fmot);
        tick(4'b1001);
        run_to_idle(500, up_c, dn_c, door_c, fdoor, fmot);
        check("dir_first_motor_up", fmot, 1);
        check("dir_first_stop", fdoor, 3);
        check("dir_up_cycles", up_c, 2 * TRAVEL);
        check("dir_down_cycles", dn_c, 3 * TRAVEL);
        check("dir_final_floor", int'(bus.floor), 0);

        // Door at floor 2 re-called on its 3rd open cycle.
        do_reset();
        tick(4'b0100);
        door_c = 0; injected = 1'b0; pend2 = 1'b0; seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            c = (door_c == 3 && !injected) ? 4'b0100 : 4'b0000;
            if (c != 4'b0000) injected = 1'b1;
            tick(c);
            if (bus.door_open) door_c++;
            if (bus.door_open && bus.pending[2]) pend2 = 1'b1;
            if (bus.busy) seen = 1'b1;
            if (seen && !bus.busy && bus.pending == 4'b0000) done = 1'b1;
        end
        check("door_extend_cycles", door_c, 3 + DOOR);
        check("door_extend_pending2", int'(pend2), 0);

        // Reset mid-travel on the 5th travel cycle takes effect without a clock edge.
        do_reset();
        tick(4'b0010);
        seen_motor = 0;
        for (int i = 0; i < 50 && seen_motor < 5; i++) begin
            tick(4'b0000);
            if (bus.motor_up) seen_motor++;
        end
        check("travel_cycles_before_reset", seen_motor, 5);
        #2 rst = 1'b1;
        #1 check("async_reset", dut_word(), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(4'b0000);
        tick(4'b0001);
        check("post_reset_latch", int'(bus.pending), 1);
        run_to_idle(100, up_c, dn_c, door_c, fdoor, fmot);
        check("post_reset_door", door_c, DOOR);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            c = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            tick(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
